// File: rtl/pipeline_trace_buffer_if.sv
// Readout port of the trace buffer: one captured entry per valid/ready handshake.
interface pipeline_trace_buffer_if #(
    parameter int W = 150
);
    logic         rd_valid;
    logic         rd_ready;
    logic [W-1:0] rd_data;
    logic         rd_last;

    modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
    modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);
endinterface

// File: rtl/pipeline_trace_buffer.sv
// Circular trace capture of IF PC and write-back result; stops POST_TRIG samples
// after a trigger and drains the captured entries oldest-first.
//
// state | meaning
// IDLE  | no capture; waiting for arm
// ARMED | sampling every cycle, watching for the trigger
// POST  | sampling the post-trigger window, post_cnt counting down
// DONE  | capture frozen; entries drained over the readout port
module pipeline_trace_buffer #(
    parameter int XLEN      = 64,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8,
    parameter int TS_W      = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [XLEN-1:0]      pc,
    input  logic                 wb_regwrite,
    input  logic [4:0]           wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 arm,
    input  logic [1:0]           trig_mode,
    input  logic [XLEN-1:0]      trig_pc,
    input  logic [4:0]           trig_rd,
    input  logic                 force_trig,
    output logic [1:0]           state,
    output logic                 wrapped,
    pipeline_trace_buffer_if.master rd
);
    localparam int EW = TS_W + 2*XLEN + 6;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   remaining_q, remaining_d;
    logic [AW-1:0]   post_cnt_q, post_cnt_d;
    logic [TS_W-1:0] ts_q, ts_d;
    logic            wrapped_q, wrapped_d;
    logic            rd_valid_q, rd_valid_d;
    logic            rd_last_q, rd_last_d;
    logic            wr_en;
    logic            trig;
    logic            to_done;
    logic [EW-1:0]   sample;
    logic [EW-1:0]   mem_q [DEPTH];

    assign sample = {ts_q, pc, wb_regwrite, wb_rd, wb_data};

    always_comb begin
        trig = force_trig;
        case (trig_mode)
            2'b01:   trig = force_trig | (pc == trig_pc);
            2'b10:   trig = force_trig | (wb_regwrite & (wb_rd == trig_rd));
            default: trig = force_trig;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        post_cnt_d  = post_cnt_q;
        wrapped_d   = wrapped_q;
        ts_d        = ts_q + 1'b1;
        wr_en       = 1'b0;
        to_done     = 1'b0;
        if (arm) begin
            state_d     = ARMED;
            wr_ptr_d    = '0;
            count_d     = '0;
            wrapped_d   = 1'b0;
            remaining_d = '0;
            ts_d        = '0;
        end else begin
            case (state_q)
                ARMED, POST: begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (count_q == FULL) wrapped_d = 1'b1;
                    else                 count_d   = count_q + 1'b1;
                    if (state_q == ARMED) begin
                        if (trig) begin
                            post_cnt_d = AW'(POST_TRIG);
                            if (POST_TRIG == 0) to_done = 1'b1;
                            else                state_d = POST;
                        end
                    end else begin
                        post_cnt_d = post_cnt_q - 1'b1;
                        if (post_cnt_q == AW'(1)) to_done = 1'b1;
                    end
                    // Oldest entry sits at the next write slot once the ring has wrapped.
                    if (to_done) begin
                        state_d     = DONE;
                        rd_ptr_d    = wrapped_d ? wr_ptr_d : '0;
                        remaining_d = count_d;
                    end
                end
                DONE: begin
                    if (rd_valid_q && rd.rd_ready) begin
                        rd_ptr_d    = rd_ptr_q + 1'b1;
                        remaining_d = remaining_q - 1'b1;
                        if (remaining_q == CW'(1)) state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
        rd_valid_d = (state_d == DONE) && (remaining_d != '0);
        rd_last_d  = (state_d == DONE) && (remaining_d == CW'(1));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            post_cnt_q  <= '0;
            ts_q        <= '0;
            wrapped_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            post_cnt_q  <= post_cnt_d;
            ts_q        <= ts_d;
            wrapped_q   <= wrapped_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wr_ptr_q] <= sample;
    end

    assign state       = state_q;
    assign wrapped     = wrapped_q;
    assign rd.rd_valid = rd_valid_q;
    assign rd.rd_last  = rd_last_q;
    assign rd.rd_data  = rd_valid_q ? mem_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Directed bench for pipeline_trace_buffer with a queue-based reference model.
module tb_pipeline_trace_buffer;
    localparam int XLEN = 64;
    localparam int DEPTH = 8;
    localparam int POST_TRIG = 3;
    localparam int TS_W = 16;
    localparam int EW = TS_W + 2*XLEN + 6;

    logic            clock;
    logic            reset;
    logic [XLEN-1:0] pc;
    logic            wb_regwrite;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            arm;
    logic [1:0]      trig_mode;
    logic [XLEN-1:0] trig_pc;
    logic [4:0]      trig_rd;
    logic            force_trig;
    logic [1:0]      state;
    logic            wrapped;

    pipeline_trace_buffer_if #(.W(EW)) rd_if ();

    pipeline_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .TS_W(TS_W)) dut (
        .clock(clock), .reset(reset), .pc(pc), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .wb_data(wb_data), .arm(arm), .trig_mode(trig_mode), .trig_pc(trig_pc),
        .trig_rd(trig_rd), .force_trig(force_trig), .state(state), .wrapped(wrapped),
        .rd(rd_if)
    );

    int errors = 0;
    int checks = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: captured samples kept as an oldest-first queue.
    int              m_state = 0;
    int              m_post = 0;
    logic            m_wrapped = 1'b0;
    logic [TS_W-1:0] m_ts = '0;
    logic [EW-1:0]   cap [$];

    task automatic m_push(input logic [EW-1:0] s);
        if (cap.size() == DEPTH) begin
            m_wrapped = 1'b1;
            void'(cap.pop_front());
        end
        cap.push_back(s);
    endtask

    initial forever begin
        logic          m_trig;
        logic [EW-1:0] s;
        @(posedge clock or posedge reset);
        if (reset) begin
            m_state = 0; m_post = 0; m_wrapped = 1'b0; m_ts = '0; cap.delete();
        end else begin
            s = {m_ts, pc, wb_regwrite, wb_rd, wb_data};
            m_trig = force_trig || (trig_mode == 2'b01 && pc == trig_pc) ||
                     (trig_mode == 2'b10 && wb_regwrite && wb_rd == trig_rd);
            if (arm) begin
                m_state = 1; cap.delete(); m_wrapped = 1'b0; m_ts = '0;
            end else begin
                m_ts = m_ts + 1'b1;
                case (m_state)
                    1: begin
                        m_push(s);
                        if (m_trig) begin
                            m_post = POST_TRIG;
                            m_state = (POST_TRIG == 0) ? 3 : 2;
                        end
                    end
                    2: begin
                        m_push(s);
                        m_post--;
                        if (m_post == 0) m_state = 3;
                    end
                    3: if (rd_if.rd_ready && cap.size() > 0) begin
                        void'(cap.pop_front());
                        if (cap.size() == 0) m_state = 0;
                    end
                    default: ;
                endcase
            end
        end
    end

    initial forever begin
        logic m_valid;
        @(negedge clock);
        if (!reset) begin
            m_valid = (m_state == 3) && (cap.size() != 0);
            check("state", state, m_state);
            check("wrapped", wrapped, m_wrapped);
            check("rd_valid", rd_if.rd_valid, m_valid);
            if (m_valid) begin
                check("rd_data", rd_if.rd_data, cap[0]);
                check("rd_last", rd_if.rd_last, cap.size() == 1);
            end
        end
    end

    logic [EW-1:0] got [$];
    logic          lasts [$];

    function automatic logic [XLEN-1:0] f_pc(input logic [EW-1:0] e);
        return e[XLEN+6 +: XLEN];
    endfunction
    function automatic logic [TS_W-1:0] f_ts(input logic [EW-1:0] e);
        return e[2*XLEN+6 +: TS_W];
    endfunction
    function automatic logic [XLEN-1:0] f_data(input logic [EW-1:0] e);
        return e[XLEN-1:0];
    endfunction
    function automatic logic [5:0] f_rwrd(input logic [EW-1:0] e);
        return e[XLEN +: 6];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        pc = pc + 64'd4;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 60 && state != 2'd3; i++) tick();
        check(name, state, 2'd3);
    endtask

    task automatic drain(input bit bp, input int max_n, output int n);
        logic [EW-1:0] prev;
        logic          stalled;
        n = 0;
        stalled = 1'b0;
        prev = '0;
        got.delete();
        lasts.delete();
        for (int i = 0; i < 100 && n < max_n; i++) begin
            rd_if.rd_ready = bp ? (i % 3 == 0) : 1'b1;
            @(negedge clock);
            if (stalled) check("hold_data", rd_if.rd_data, prev);
            stalled = rd_if.rd_valid && !rd_if.rd_ready;
            prev = rd_if.rd_data;
            if (rd_if.rd_valid && rd_if.rd_ready) begin
                got.push_back(rd_if.rd_data);
                lasts.push_back(rd_if.rd_last);
                n++;
            end
            tick();
        end
        rd_if.rd_ready = 1'b0;
    endtask

    task automatic run_manual(input string tag);
        int n;
        pc = 64'h0C; trig_mode = 2'b00;
        arm = 1'b1; tick(); arm = 1'b0;
        check({tag, "_armed"}, state, 2'd1);
        tick(); tick();
        force_trig = 1'b1; tick(); force_trig = 1'b0;
        check({tag, "_post"}, state, 2'd2);
        tick(); tick(); tick();
        check({tag, "_done"}, state, 2'd3);
        check({tag, "_wrapped"}, wrapped, 1'b0);
        check({tag, "_valid"}, rd_if.rd_valid, 1'b1);
        drain(1'b0, 6, n);
        check({tag, "_count"}, n, 6);
        for (int i = 0; i < 6; i++) begin
            check({tag, "_pc"}, f_pc(got[i]), 64'h10 + 64'(4*i));
            check({tag, "_ts"}, f_ts(got[i]), 16'(i));
        end
        check({tag, "_last6"}, lasts[5], 1'b1);
        check({tag, "_last5"}, lasts[4], 1'b0);
        check({tag, "_idle"}, state, 2'd0);
    endtask

    initial begin
        int n;
        reset = 1'b0; pc = '0; wb_regwrite = 1'b0; wb_rd = 5'd0; wb_data = '0;
        arm = 1'b0; trig_mode = 2'b00; trig_pc = '0; trig_rd = 5'd0; force_trig = 1'b0;
        rd_if.rd_ready = 1'b0;
        #2 reset = 1'b1;
        #2;
        check("rst_state", state, 2'd0);
        check("rst_wrapped", wrapped, 1'b0);
        check("rst_valid", rd_if.rd_valid, 1'b0);
        check("rst_last", rd_if.rd_last, 1'b0);
        check("rst_data", rd_if.rd_data, '0);
        @(posedge clock); #1 reset = 1'b0;

        run_manual("s1");

        pc = 64'h00; trig_mode = 2'b01; trig_pc = 64'h40;
        arm = 1'b1; tick(); arm = 1'b0;
        wait_done("s2_done");
        check("s2_wrapped", wrapped, 1'b1);
        drain(1'b0, 8, n);
        check("s2_count", n, 8);
        for (int i = 0; i < 8; i++) begin
            check("s2_pc", f_pc(got[i]), 64'h30 + 64'(4*i));
            check("s2_ts", f_ts(got[i]), 16'(11 + i));
        end

        pc = 64'h00; trig_mode = 2'b10; trig_rd = 5'd5;
        arm = 1'b1; tick(); arm = 1'b0;
        for (int i = 0; i < 40 && state != 2'd3; i++) begin
            wb_regwrite = (pc == 64'h14) || (pc == 64'h20);
            wb_rd = ((pc == 64'h10) || (pc == 64'h20)) ? 5'd5 : 5'd3;
            wb_data = (pc == 64'h20) ? 64'hDEAD : ((pc == 64'h14) ? 64'h1111 : 64'h0);
            tick();
        end
        wb_regwrite = 1'b0; wb_rd = 5'd0; wb_data = '0;
        check("s3_done", state, 2'd3);
        drain(1'b1, 8, n);
        check("s3_count", n, 8);
        check("s3_oldest_pc", f_pc(got[0]), 64'h10);
        check("s3_other_pc", f_pc(got[1]), 64'h14);
        check("s3_other_wb", f_rwrd(got[1]), {1'b1, 5'd3});
        check("s3_other_data", f_data(got[1]), 64'h1111);
        check("s3_trig_pc", f_pc(got[n-4]), 64'h20);
        check("s3_trig_wb", f_rwrd(got[n-4]), {1'b1, 5'd5});
        check("s3_trig_data", f_data(got[n-4]), 64'hDEAD);
        check("s3_idle", state, 2'd0);

        pc = 64'h100; trig_mode = 2'b00;
        arm = 1'b1; tick(); arm = 1'b0;
        tick(); tick();
        force_trig = 1'b1; tick(); force_trig = 1'b0;
        tick();
        check("s5_post", state, 2'd2);
        arm = 1'b1; tick(); arm = 1'b0;
        check("s5_rearmed", state, 2'd1);
        tick();
        force_trig = 1'b1; tick(); force_trig = 1'b0;
        tick(); tick(); tick();
        check("s5_done", state, 2'd3);
        drain(1'b0, 5, n);
        check("s5_count", n, 5);
        check("s5_first_pc", f_pc(got[0]), 64'h118);
        check("s5_first_ts", f_ts(got[0]), 16'd0);
        check("s5_last_pc", f_pc(got[4]), 64'h128);
        check("s5_last_ts", f_ts(got[4]), 16'd4);

        pc = 64'h200; trig_mode = 2'b00;
        arm = 1'b1; tick(); arm = 1'b0;
        tick();
        force_trig = 1'b1; tick(); force_trig = 1'b0;
        tick(); tick(); tick();
        check("s6_done", state, 2'd3);
        drain(1'b0, 2, n);
        check("s6_pre_count", n, 2);
        check("s6_pre_valid", rd_if.rd_valid, 1'b1);
        reset = 1'b1;
        #1;
        check("s6_rst_state", state, 2'd0);
        check("s6_rst_valid", rd_if.rd_valid, 1'b0);
        check("s6_rst_last", rd_if.rd_last, 1'b0);
        check("s6_rst_data", rd_if.rd_data, '0);
        @(negedge clock); #2 reset = 1'b0;
        run_manual("s6b");

        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pipeline_trace_buffer.md
# pipeline_trace_buffer

Synthesizable on-chip trace capture for the pipelined datapath. It replaces per-cycle console dumps with a parametrised circular buffer. The buffer records the IF-stage PC and the write-back result (regwrite, rd, data) every cycle and stops a programmable number of cycles after a trigger. Captured entries are then drained oldest-first over a valid/ready port. It sits beside `datapath`, tapping the IF PC and the MEM/WB write-back signals; it has no influence on the pipeline.

## Interface
Parameters:
- `XLEN`, 64, width of PC and write-back data.
- `DEPTH`, 16, number of trace entries; power of two, ≥4.
- `POST_TRIG`, 8, samples captured after the trigger sample; 0 ≤ POST_TRIG ≤ DEPTH-1.
- `TS_W`, 16, timestamp width.

Ports:
- `clock`, in, 1, single clock; all state updates on its rising edge.
- `reset`, in, 1, asynchronous, active-high; returns the block to IDLE.
- `pc`, in, XLEN, IF-stage PC.
- `wb_regwrite`, in, 1, write-back enable (MEM/WB stage).
- `wb_rd`, in, 5, write-back destination register.
- `wb_data`, in, XLEN, write-back data.
- `arm`, in, 1, start or restart a capture (level sampled each cycle).
- `trig_mode`, in, 2, trigger source:
  - 00: manual (`force_trig` only).
  - 01: PC match.
  - 10: write-back to `trig_rd` with `wb_regwrite`=1.
  - 11: never (free run).
- `trig_pc`, in, XLEN, PC compare value.
- `trig_rd`, in, 5, rd compare value.
- `force_trig`, in, 1, immediate trigger in any mode.
- `state`, out, 2, IDLE=0, ARMED=1, POST=2, DONE=3.
- `wrapped`, out, 1, buffer overwrote at least one entry in this capture.
- `rd_valid`, out, 1, readout entry available.
- `rd_ready`, in, 1, consumer accepts entry.
- `rd_data`, out, TS_W+2*XLEN+6, entry {timestamp, pc, wb_regwrite, wb_rd, wb_data}, MSB first.
- `rd_last`, out, 1, current entry is the final one.

## Operation
- Reset values: `state`=IDLE, `wrapped`=0, `rd_valid`=0, `rd_last`=0, `rd_data`=0; all pointers and counters are 0. Buffer contents are undefined.
- IDLE: no writes. `arm`=1 moves to ARMED and clears `wr_ptr`, `count`, `wrapped` and the timestamp.
- ARMED:
  - Each cycle, write the entry at `wr_ptr`, then `wr_ptr`+1 modulo DEPTH.
  - `count` saturates at DEPTH; writing while `count`=DEPTH sets `wrapped`.
  - A trigger (selected condition or `force_trig`) in a cycle writes that cycle's sample, then moves to POST with `post_cnt`=POST_TRIG.
  - If POST_TRIG=0, the trigger moves directly to DONE.
- POST: write each cycle and decrement `post_cnt`. The write that takes `post_cnt` to 0 also moves the block to DONE. Triggers are ignored.
- DONE:
  - No writes.
  - Readout start pointer is `wr_ptr` if `wrapped`, else 0. `remaining` = `count`.
  - `rd_valid` = (`remaining`≠0). `rd_last` = (`remaining`=1).
  - A handshake (`rd_valid`&`rd_ready`) advances `rd_ptr` modulo DEPTH and decrements `remaining`.
  - The handshake on the last entry returns to IDLE.
- Timestamp: a TS_W counter cleared on arm that increments every cycle and wraps silently. The first ARMED sample carries 0.
- `arm`=1 in ARMED, POST or DONE aborts the current capture and restarts exactly as from IDLE. Pending readout is discarded and `rd_valid` drops the next cycle.
- `arm` has priority over a trigger or handshake in the same cycle.

## Timing
- `arm` sampled at edge N; the first sample is taken at edge N+1 (`state`=ARMED during cycle N+1).
- Trigger condition is combinational on the current-cycle inputs. The sample at the trigger edge is stored. `state` shows POST or DONE from the next cycle.
- DONE is entered after exactly POST_TRIG further samples. `rd_valid` is asserted in the first DONE cycle.
- `rd_data` and `rd_last` are stable while `rd_valid`&!`rd_ready`. One entry is accepted per cycle at full throughput.
- Asserting `reset` mid-capture or mid-readout forces the reset values immediately, independent of `clock`.

## Test plan
Bench stimulus: PC increments by 4 each cycle; DEPTH=8, POST_TRIG=3.

- **Manual trigger, no wrap:** `arm` in the cycle with pc=0x0C; mode 00; `force_trig` in the cycle with pc=0x18 → 6 entries with pc 0x10..0x24 and timestamps 0..5; `rd_last` on the 6th; `wrapped`=0; then IDLE.
- **PC match with wrap:** `arm` at pc=0x00; mode 01; `trig_pc`=0x40 → 8 entries with pc 0x30..0x4C oldest-first; `wrapped`=1.
- **rd trigger:** mode 10; `trig_rd`=5; `wb_regwrite`=1 with `wb_rd`=5 and `wb_data`=0xDEAD at pc=0x20 → the entry with pc 0x20 has `wb_data`=0xDEAD and is 4th from last.
- **Backpressure:** `rd_ready` toggled 1,0,0,1... → no entry is lost or duplicated, and `rd_data` holds while stalled.
- **Restart:** `arm` pulsed during POST → `state`=ARMED next cycle, timestamp restarts at 0, the old samples are never read.
- **Reset:** `reset` mid-readout after 2 entries → `rd_valid`=0 and IDLE immediately; a fresh capture then reads normally.
